// File: rtl/mine_field_gen.sv
`timescale 1ns/1ps
// Minesweeper minefield generator: clears the map, drops MINES mines from a free-running LFSR outside the 3x3 zone around the first click, then answers cell queries.
// Latency: CLEAR takes ROWS*COLS cycles, PLACE takes MINES cycles plus one per rejected candidate, and a query responds 10 cycles after accept.
// Backpressure: start is taken only in IDLE/READY and query_valid only while query_ready; anything offered at other times is dropped.
module mine_field_gen #(
    parameter int          ROWS  = 8,
    parameter int          COLS  = 8,
    parameter int          MINES = 10,
    parameter logic [31:0] SEED  = 32'hFE37C0DE,
    localparam int         RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int         CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [RW-1:0] safe_row,
    input  logic [CW-1:0] safe_col,
    output logic          busy,
    output logic          done,
    output logic          query_ready,
    input  logic          query_valid,
    input  logic [RW-1:0] query_row,
    input  logic [CW-1:0] query_col,
    output logic          rsp_valid,
    output logic          rsp_mine,
    output logic [3:0]    rsp_count
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);
    localparam int PW    = $clog2(MINES + 1);

    localparam logic [AW:0]   CELLS_X   = (AW+1)'(CELLS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [PW-1:0] LAST_MINE = PW'(MINES - 1);
    localparam logic [RW:0]   ROWS_X    = (RW+1)'(ROWS);
    localparam logic [CW:0]   COLS_X    = (CW+1)'(COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLACE,
        S_READY,
        S_QUERY
    } state_t;

    state_t          state_q, state_d;

    logic [31:0]     lfsr_q;
    logic            lfsr_fb;

    logic [RW-1:0]   safe_r_q, qrow_q;
    logic [CW-1:0]   safe_c_q, qcol_q;
    logic [AW-1:0]   clear_addr_q;
    logic [PW-1:0]   placed_q;
    logic [3:0]      scan_q;
    logic [3:0]      acc_q;
    logic            centre_q;
    logic            done_q;
    logic            rsp_valid_q;
    logic            rsp_mine_q;
    logic [3:0]      rsp_count_q;

    // Mine map; contents are meaningless until a CLEAR pass has run.
    logic [CELLS-1:0] map_q;

    logic [RW-1:0]   cand_row;
    logic [CW-1:0]   cand_col;
    logic            cand_in, cand_safe, cand_ok, place_last;
    logic [AW-1:0]   cand_addr;

    logic            go_up, go_dn, go_lt, go_rt;
    logic [RW:0]     nb_row;
    logic [CW:0]     nb_col;
    logic            nb_in, nb_bit;
    logic [AW-1:0]   nb_addr;

    logic [AW-1:0]   map_addr;
    logic            map_rd, map_we, map_wd;

    logic            start_take, query_take;

    assign lfsr_fb  = lfsr_q[22] ^ lfsr_q[2] ^ lfsr_q[1] ^ lfsr_q[0];
    assign cand_row = lfsr_q[RW+CW-1:CW];
    assign cand_col = lfsr_q[CW-1:0];

    assign start_take = start && ((state_q == S_IDLE) || (state_q == S_READY));
    assign query_take = query_valid && !start && (state_q == S_READY);

    // Candidate screening: inside the board, outside the first-click 3x3 zone, cell still empty.
    always_comb begin
        cand_in   = ({1'b0, cand_row} < ROWS_X) && ({1'b0, cand_col} < COLS_X);
        cand_safe = ({1'b0, cand_row} + (RW+1)'(1) >= {1'b0, safe_r_q}) &&
                    ({1'b0, cand_row} <= {1'b0, safe_r_q} + (RW+1)'(1)) &&
                    ({1'b0, cand_col} + (CW+1)'(1) >= {1'b0, safe_c_q}) &&
                    ({1'b0, cand_col} <= {1'b0, safe_c_q} + (CW+1)'(1));
        cand_addr = AW'(cand_row) * COLS_A + AW'(cand_col);
        cand_ok   = cand_in && !cand_safe && !map_rd;
        place_last = cand_ok && (placed_q == LAST_MINE);
    end

    // Neighbour walk: scan step 0 is the centre, 1..8 are NW, N, NE, W, E, SW, S, SE.
    always_comb begin
        go_up = 1'b0;
        go_dn = 1'b0;
        go_lt = 1'b0;
        go_rt = 1'b0;
        case (scan_q)
            4'd1:    begin go_up = 1'b1; go_lt = 1'b1; end
            4'd2:    go_up = 1'b1;
            4'd3:    begin go_up = 1'b1; go_rt = 1'b1; end
            4'd4:    go_lt = 1'b1;
            4'd5:    go_rt = 1'b1;
            4'd6:    begin go_dn = 1'b1; go_lt = 1'b1; end
            4'd7:    go_dn = 1'b1;
            4'd8:    begin go_dn = 1'b1; go_rt = 1'b1; end
            default: ;
        endcase
        nb_row = {1'b0, qrow_q};
        nb_col = {1'b0, qcol_q};
        if (go_up) nb_row = nb_row - (RW+1)'(1);
        if (go_dn) nb_row = nb_row + (RW+1)'(1);
        if (go_lt) nb_col = nb_col - (CW+1)'(1);
        if (go_rt) nb_col = nb_col + (CW+1)'(1);
        // Stepping off row/col 0 wraps to all-ones, which the range check rejects: no edge wrap.
        nb_in   = (nb_row < ROWS_X) && (nb_col < COLS_X);
        nb_addr = AW'(nb_row) * COLS_A + AW'(nb_col);
        nb_bit  = nb_in && map_rd;
    end

    // Single map port: the address comes from whichever phase owns the map this cycle.
    assign map_rd = ({1'b0, map_addr} < CELLS_X) ? map_q[map_addr] : 1'b0;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start beats a simultaneous query in READY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: if (clear_addr_q == LAST_ADDR) state_d = S_PLACE;
            S_PLACE: if (place_last) state_d = S_READY;
            S_READY: begin
                if (start)            state_d = S_CLEAR;
                else if (query_valid) state_d = S_QUERY;
            end
            S_QUERY: if (scan_q == 4'd8) state_d = S_READY;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and map port control.
    always_comb begin
        busy        = 1'b0;
        query_ready = 1'b0;
        map_addr    = '0;
        map_we      = 1'b0;
        map_wd      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy     = 1'b1;
                map_addr = clear_addr_q;
                map_we   = 1'b1;
                map_wd   = 1'b0;
            end
            S_PLACE: begin
                busy     = 1'b1;
                map_addr = cand_addr;
                map_we   = cand_ok;
                map_wd   = 1'b1;
            end
            S_READY: query_ready = 1'b1;
            S_QUERY: map_addr = nb_addr;
            default: ;
        endcase
    end

    // Map storage is deliberately unreset; CLEAR initialises it before any use.
    always_ff @(posedge clock) begin
        if (map_we) begin
            map_q[map_addr] <= map_wd;
        end
    end

    // LFSR free-runs in every state so the player's timing perturbs the layout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= (lfsr_q << 1) | {31'd0, lfsr_fb};
        end
    end

    // Game setup counters: safe cell latch, clear sweep, placed-mine count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            safe_r_q     <= '0;
            safe_c_q     <= '0;
            clear_addr_q <= '0;
            placed_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_q == S_PLACE) && place_last;
            if (start_take) begin
                safe_r_q     <= safe_row;
                safe_c_q     <= safe_col;
                clear_addr_q <= '0;
            end else if (state_q == S_CLEAR) begin
                clear_addr_q <= clear_addr_q + AW'(1);
                if (clear_addr_q == LAST_ADDR) begin
                    placed_q <= '0;
                end
            end else if ((state_q == S_PLACE) && cand_ok) begin
                placed_q <= placed_q + PW'(1);
            end
        end
    end

    // Query engine: latch coordinates, walk nine cells, register the answer on the last step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qrow_q      <= '0;
            qcol_q      <= '0;
            scan_q      <= '0;
            acc_q       <= '0;
            centre_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_mine_q  <= 1'b0;
            rsp_count_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (query_take) begin
                qrow_q <= query_row;
                qcol_q <= query_col;
                scan_q <= '0;
                acc_q  <= '0;
            end else if (state_q == S_QUERY) begin
                scan_q <= scan_q + 4'd1;
                if (scan_q == 4'd0) begin
                    centre_q <= nb_bit;
                end else begin
                    acc_q <= acc_q + {3'b000, nb_bit};
                end
                if (scan_q == 4'd8) begin
                    rsp_valid_q <= 1'b1;
                    rsp_mine_q  <= centre_q;
                    rsp_count_q <= acc_q + {3'b000, nb_bit};
                end
            end
        end
    end

    assign done      = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mine  = rsp_mine_q;
    assign rsp_count = rsp_count_q;

endmodule
